// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for MIPS div/divu in EX; 33 cycles from start to ready, 2 for a zero divisor.
// No backpressure: EX holds start_i until ready_o, and stallreq_o freezes the pipeline meanwhile.
module ex_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam logic [1:0] S_FREE   = 2'b00;
  localparam logic [1:0] S_BYZERO = 2'b01;
  localparam logic [1:0] S_ON     = 2'b10;
  localparam logic [1:0] S_END    = 2'b11;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic               signed_q, signed_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  // Operand magnitudes, only meaningful in the cycle start_i is accepted
  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] op1_abs, op2_abs;

  assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // One restoring step: the shifted partial remainder is WIDTH+1 bits wide, so
  // the top bit of the subtraction is the borrow.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             neg_quo;
  logic             neg_rem;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [CNT_W-1:0] cnt_inc;

  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign qbit     = ~trial[WIDTH];
  assign rem_step = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step = {dvd_q[WIDTH-2:0], qbit};
  assign cnt_inc  = cnt_q + 1'b1;

  // Sign correction; the most-negative / -1 case wraps to itself.
  assign neg_quo = signed_q & (sign1_q ^ sign2_q);
  assign neg_rem = signed_q & sign1_q;
  assign quo_fix = neg_quo ? (~quo_step + 1'b1) : quo_step;
  assign rem_fix = neg_rem ? (~rem_step + 1'b1) : rem_step;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    signed_d = signed_q;
    ready_d  = ready_q;
    result_d = result_q;

    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d  = S_ON;
            dvd_d    = op1_abs;
            dvs_d    = op2_abs;
            rem_d    = '0;
            cnt_d    = '0;
            sign1_d  = opdata1_i[WIDTH-1];
            sign2_d  = opdata2_i[WIDTH-1];
            signed_d = signed_div_i;
          end
        end
      end

      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end

      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          dvd_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(WIDTH)) begin
            state_d  = S_END;
            ready_d  = 1'b1;
            result_d = {rem_fix, quo_fix};
          end
        end
      end

      default: begin
        if (annul_i || !start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      signed_q <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      signed_q <= signed_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative 32-bit divider in the EX stage, directly upstream of the MEM stage.
- Serves MIPS div/divu: the EX stage raises start_i and holds the instruction in EX (via stallreq_o into the stall controller) until ready_o.
- EX then forwards {remainder, quotient} as the HI/LO write data in ex_to_mem_bus.
- Restoring radix-2 algorithm, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, width of the iteration counter; must hold the value WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- start_i  input  1  divide request from EX decode; held high by EX until the result is consumed
- signed_div_i  input  1  1 = div (signed), 0 = divu; sampled with start_i in FREE
- opdata1_i  input  WIDTH  dividend; sampled in FREE
- opdata2_i  input  WIDTH  divisor; sampled in FREE
- annul_i  input  1  cancel the in-flight divide (EX flush)
- result_o  output  2*WIDTH  {remainder[63:32], quotient[31:0]}
- ready_o  output  1  result_o valid
- stallreq_o  output  1  stall request to the stall controller; drives stall[2] (EX) and everything upstream

Behaviour:
- States: FREE, BYZERO, ON, END. Registered outputs are result_o and ready_o.
- Reset (rst=1 at clk edge): state=FREE, cnt=0, ready_o=0, result_o=0, internal dividend/divisor/partial-remainder registers=0. Reset applies in any state and aborts an operation mid-flight.
- FREE:
  - start_i=1, annul_i=0, opdata2_i==0 -> BYZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 -> ON. Latch |op1|, |op2| (absolute values when signed_div_i=1, raw otherwise), latch both sign bits and signed_div_i, set partial remainder=0, cnt=0.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: next edge -> END with result_o=0 and ready_o=1.
- ON:
  - Each cycle: shift {rem, dividend} left 1; trial = rem - divisor. If trial is non-negative (no borrow), rem=trial and the quotient bit is 1; else the quotient bit is 0. cnt increments.
  - After the 32nd iteration (cnt reaches WIDTH) -> END.
  - Signed correction on entering END: quotient negated if the two operand signs differ; remainder negated if the dividend sign is 1.
  - Results are two's-complement WIDTH bits, wrap permitted: 0x80000000 / 0xFFFFFFFF signed gives q=0x80000000, r=0.
  - annul_i=1 in ON -> FREE next edge, ready_o stays 0, result discarded.
- END:
  - ready_o=1 and result_o is held stable.
  - Stay in END while start_i=1.
  - start_i=0 -> FREE next edge, ready_o=0, result_o=0.
  - annul_i=1 -> FREE.
- Latency, with start sampled at edge t:
  - Non-zero divisor: ON for 32 cycles, ready_o=1 from cycle t+33.
  - Zero divisor: ready_o=1 from cycle t+2.
- stallreq_o (combinational) = start_i & ~ready_o & ~annul_i. The EX instruction is therefore frozen exactly until the first cycle ready_o=1. That cycle EX passes result_o to the MEM stage register.
- Operand changes on opdata*_i after leaving FREE are ignored.
- annul_i has priority over start_i in every state.

Test Plan:
- Unsigned 100/7, start held: stallreq_o=1 for cycles t..t+32; at t+33 ready_o=1, result_o={32'd2, 32'd14}, stallreq_o=0. Drop start -> ready_o=0, result_o=0 next cycle.
- Signed -7/2 (0xFFFFFFF9 / 0x2): result_o={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2: result_o={0x00000001, 0xFFFFFFFD}.
- Divide by zero (any dividend, op2=0): ready_o=1 at t+2, result_o=0, no ON cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: result_o={0x0, 0x80000000}. Unsigned 0xFFFFFFFF/1: {0x0, 0xFFFFFFFF}.
- annul_i pulsed at cycle t+10 -> FREE, ready_o never rises. New start 9/3 then gives {0, 3} at its own t'+33. rst at t+5 -> all outputs 0, state FREE.
- Back-to-back: after END, deassert start 1 cycle, restart 0xFFFFFFFF/0x10000 unsigned -> {0x0000FFFF, 0x0000FFFF}. Operands changed mid-ON do not alter the result.
